// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and constants for the IF/MEM memory port arbiter.
package mem_bus_arbiter_pkg;

    localparam int unsigned XLEN     = 64;
    localparam int unsigned MASK_W   = XLEN / 8;
    localparam int unsigned STARVE_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } state_e;

    typedef enum logic {
        OWN_IF  = 1'b0,
        OWN_MEM = 1'b1
    } owner_e;

    // Request payload held on the memory bus from ADDR entry until grant
    typedef struct packed {
        logic              we;
        logic [XLEN-1:0]   addr;
        logic [XLEN-1:0]   wdata;
        logic [MASK_W-1:0] wmask;
    } bus_req_t;

endpackage

// File: rtl/mem_bus_arbiter.sv
// Arbitrates the single memory port between instruction fetch and load/store,
// one outstanding transaction at a time; flushes cancel or discard fetches.
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush_i,

    input  logic              if_req_i,
    input  logic [XLEN-1:0]   if_addr_i,
    output logic [XLEN-1:0]   if_rdata_o,
    output logic              if_rvalid_o,

    input  logic              mem_req_i,
    input  logic              mem_we_i,
    input  logic [XLEN-1:0]   mem_addr_i,
    input  logic [XLEN-1:0]   mem_wdata_i,
    input  logic [MASK_W-1:0] mem_wmask_i,
    output logic [XLEN-1:0]   mem_rdata_o,
    output logic              mem_rvalid_o,

    output logic              bus_req_o,
    output logic              bus_we_o,
    output logic [XLEN-1:0]   bus_addr_o,
    output logic [XLEN-1:0]   bus_wdata_o,
    output logic [MASK_W-1:0] bus_wmask_o,
    input  logic              bus_gnt_i,
    input  logic              bus_rvalid_i,
    input  logic [XLEN-1:0]   bus_rdata_i,

    output logic              hold_flag_if_o,
    output logic              hold_flag_mem_o
);

    localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

    state_e              state_q,   state_d;
    owner_e              owner_q,   owner_d;
    logic                discard_q, discard_d;
    logic [STARVE_W-1:0] starve_q,  starve_d;
    logic                bus_req_q, bus_req_d;
    bus_req_t            bus_q,     bus_d;

    logic if_eligible;
    logic if_forced;
    logic if_flushed;
    logic resp_fire;

    // State and registered bus payload
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            owner_q   <= OWN_MEM;
            discard_q <= 1'b0;
            starve_q  <= '0;
            bus_req_q <= 1'b0;
            bus_q     <= '0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            discard_q <= discard_d;
            starve_q  <= starve_d;
            bus_req_q <= bus_req_d;
            bus_q     <= bus_d;
        end
    end

    // Next state, arbitration and response routing
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        discard_d    = discard_q;
        starve_d     = starve_q;
        bus_req_d    = bus_req_q;
        bus_d        = bus_q;
        if_rvalid_o  = 1'b0;
        mem_rvalid_o = 1'b0;

        if_eligible = if_req_i && !flush_i;
        if_forced   = if_eligible && (starve_q == STARVE_MAX);
        if_flushed  = (owner_q == OWN_IF) && flush_i;
        resp_fire   = (state_q == ST_DATA) && bus_rvalid_i;

        unique case (state_q)
            ST_IDLE: begin
                if (!if_req_i) begin
                    starve_d = '0;
                end
                if (mem_req_i && !if_forced) begin
                    owner_d     = OWN_MEM;
                    bus_d.we    = mem_we_i;
                    bus_d.addr  = mem_addr_i;
                    bus_d.wdata = mem_wdata_i;
                    bus_d.wmask = mem_wmask_i;
                    bus_req_d   = 1'b1;
                    state_d     = ST_ADDR;
                    if (if_req_i && (starve_q != STARVE_MAX)) begin
                        starve_d = starve_q + STARVE_W'(1);
                    end
                end else if (if_eligible) begin
                    owner_d     = OWN_IF;
                    bus_d.we    = 1'b0;
                    bus_d.addr  = if_addr_i;
                    bus_d.wdata = '0;
                    bus_d.wmask = '0;
                    bus_req_d   = 1'b1;
                    state_d     = ST_ADDR;
                    starve_d    = '0;
                end
            end

            ST_ADDR: begin
                // A grant wins over a same-cycle flush; the data is then discarded
                if (bus_gnt_i) begin
                    state_d   = ST_DATA;
                    bus_req_d = 1'b0;
                    if (if_flushed) begin
                        discard_d = 1'b1;
                    end
                end else if (if_flushed) begin
                    state_d   = ST_IDLE;
                    bus_req_d = 1'b0;
                end
            end

            ST_DATA: begin
                if (if_flushed) begin
                    discard_d = 1'b1;
                end
                if (bus_rvalid_i) begin
                    state_d   = ST_IDLE;
                    discard_d = 1'b0;
                end
            end

            default: begin
                state_d   = ST_IDLE;
                bus_req_d = 1'b0;
            end
        endcase

        if (resp_fire) begin
            if (owner_q == OWN_MEM) begin
                mem_rvalid_o = 1'b1;
            end else begin
                if_rvalid_o = !discard_q && !flush_i;
            end
        end
    end

    assign if_rdata_o  = bus_rdata_i;
    assign mem_rdata_o = bus_rdata_i;

    assign bus_req_o   = bus_req_q;
    assign bus_we_o    = bus_q.we;
    assign bus_addr_o  = bus_q.addr;
    assign bus_wdata_o = bus_q.wdata;
    assign bus_wmask_o = bus_q.wmask;

    // A flushed fetch is not a stall: the controller redirects instead
    assign hold_flag_if_o  = if_req_i && !if_rvalid_o && !flush_i;
    assign hold_flag_mem_o = mem_req_i && !mem_rvalid_o;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench with a behavioural memory and per-requester scoreboards.
module tb_mem_bus_arbiter;

    logic        clk;
    logic        rst_n;
    logic        flush_i;
    logic        if_req_i;
    logic [63:0] if_addr_i;
    logic [63:0] if_rdata_o;
    logic        if_rvalid_o;
    logic        mem_req_i;
    logic        mem_we_i;
    logic [63:0] mem_addr_i;
    logic [63:0] mem_wdata_i;
    logic [7:0]  mem_wmask_i;
    logic [63:0] mem_rdata_o;
    logic        mem_rvalid_o;
    logic        bus_req_o;
    logic        bus_we_o;
    logic [63:0] bus_addr_o;
    logic [63:0] bus_wdata_o;
    logic [7:0]  bus_wmask_o;
    logic        bus_gnt_i;
    logic        bus_rvalid_i;
    logic [63:0] bus_rdata_i;
    logic        hold_flag_if_o;
    logic        hold_flag_mem_o;

    mem_bus_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .flush_i         (flush_i),
        .if_req_i        (if_req_i),
        .if_addr_i       (if_addr_i),
        .if_rdata_o      (if_rdata_o),
        .if_rvalid_o     (if_rvalid_o),
        .mem_req_i       (mem_req_i),
        .mem_we_i        (mem_we_i),
        .mem_addr_i      (mem_addr_i),
        .mem_wdata_i     (mem_wdata_i),
        .mem_wmask_i     (mem_wmask_i),
        .mem_rdata_o     (mem_rdata_o),
        .mem_rvalid_o    (mem_rvalid_o),
        .bus_req_o       (bus_req_o),
        .bus_we_o        (bus_we_o),
        .bus_addr_o      (bus_addr_o),
        .bus_wdata_o     (bus_wdata_o),
        .bus_wmask_o     (bus_wmask_o),
        .bus_gnt_i       (bus_gnt_i),
        .bus_rvalid_i    (bus_rvalid_i),
        .bus_rdata_i     (bus_rdata_i),
        .hold_flag_if_o  (hold_flag_if_o),
        .hold_flag_mem_o (hold_flag_mem_o)
    );

    typedef struct packed {
        logic        store;
        logic [7:0]  wmask;
        logic [63:0] data;
    } mem_exp_t;

    logic [63:0] if_q[$];
    mem_exp_t    mem_q[$];
    int          n_checks = 0;
    int          n_pass   = 0;

    // Requester inputs staged by the test, applied mid-cycle by step()
    logic        s_rst_n     = 1'b0;
    logic        s_flush     = 1'b0;
    logic        s_if_req    = 1'b0;
    logic [63:0] s_if_addr   = '0;
    logic        s_mem_req   = 1'b0;
    logic        s_mem_we    = 1'b0;
    logic [63:0] s_mem_addr  = '0;
    logic [63:0] s_mem_wdata = '0;
    logic [7:0]  s_mem_wmask = '0;

    // Memory model state
    logic        gnt_hold   = 1'b0;
    int          rsp_delay  = 1;
    logic        pend       = 1'b0;
    logic        pend_we    = 1'b0;
    int          pend_cnt   = 0;
    logic [63:0] pend_addr  = '0;
    logic        cand_we    = 1'b0;
    logic [63:0] cand_addr  = '0;
    logic [63:0] cand_wdata = '0;
    logic [7:0]  cand_wmask = '0;
    logic [63:0] wr_wdata   = '0;
    logic [7:0]  wr_wmask   = '0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [63:0] mem_data(input logic [63:0] a);
        if (a == 64'h80) begin
            return 64'h1122_3344_5566_7788;
        end
        return {a[31:0] ^ 32'hCAFE_F00D, ~a[31:0]};
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got 0x%h expected 0x%h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic mem_push(input logic st, input logic [7:0] m, input logic [63:0] d);
        mem_exp_t e;
        e.store = st;
        e.wmask = m;
        e.data  = d;
        mem_q.push_back(e);
    endtask

    // Memory: grants immediately unless held, answers rsp_delay cycles after grant
    always @(negedge clk) begin
        #1;
        bus_gnt_i    = bus_req_o && !gnt_hold && !pend;
        bus_rvalid_i = pend && (pend_cnt == 0);
        bus_rdata_i  = (bus_rvalid_i && !pend_we) ? mem_data(pend_addr) : 64'hBAD0_BAD0_BAD0_BAD0;
        cand_we      = bus_we_o;
        cand_addr    = bus_addr_o;
        cand_wdata   = bus_wdata_o;
        cand_wmask   = bus_wmask_o;
    end

    always @(posedge clk) begin
        if (!rst_n) begin
            pend = 1'b0;
        end else if (bus_gnt_i) begin
            pend      = 1'b1;
            pend_cnt  = rsp_delay - 1;
            pend_addr = cand_addr;
            pend_we   = cand_we;
            if (cand_we) begin
                wr_wdata = cand_wdata;
                wr_wmask = cand_wmask;
            end
        end else if (bus_rvalid_i) begin
            pend = 1'b0;
        end else if (pend && pend_cnt != 0) begin
            pend_cnt--;
        end
    end

    // One cycle: apply staged inputs, then score any completion pulses
    task automatic step();
        mem_exp_t e;
        @(negedge clk);
        #2;
        rst_n       = s_rst_n;
        flush_i     = s_flush;
        if_req_i    = s_if_req;
        if_addr_i   = s_if_addr;
        mem_req_i   = s_mem_req;
        mem_we_i    = s_mem_we;
        mem_addr_i  = s_mem_addr;
        mem_wdata_i = s_mem_wdata;
        mem_wmask_i = s_mem_wmask;
        #1;
        if (if_rvalid_o) begin
            if (if_q.size() == 0) check("if_spurious", 64'(if_rvalid_o), 64'd0);
            else check("if_rdata", if_rdata_o, if_q.pop_front());
        end
        if (mem_rvalid_o) begin
            if (mem_q.size() == 0) begin
                check("mem_spurious", 64'(mem_rvalid_o), 64'd0);
            end else begin
                e = mem_q.pop_front();
                if (e.store) begin
                    check("st_wdata", wr_wdata, e.data);
                    check("st_wmask", 64'(wr_wmask), 64'(e.wmask));
                end else begin
                    check("mem_rdata", mem_rdata_o, e.data);
                end
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; flush_i = 1'b0; if_req_i = 1'b0; if_addr_i = '0;
        mem_req_i = 1'b0; mem_we_i = 1'b0; mem_addr_i = '0; mem_wdata_i = '0; mem_wmask_i = '0;
        bus_gnt_i = 1'b0; bus_rvalid_i = 1'b0; bus_rdata_i = '0;

        step(); step();
        s_rst_n = 1'b1;
        step();
        check("rst_bus_req", 64'(bus_req_o), 64'd0);
        check("rst_bus_addr", bus_addr_o, 64'd0);
        check("rst_mem_rvalid", 64'(mem_rvalid_o), 64'd0);

        // MEM load against a single-cycle memory
        s_mem_addr = 64'h80; s_mem_req = 1'b1;
        mem_push(1'b0, 8'h00, 64'h1122_3344_5566_7788);
        step();
        check("t1_req_n", 64'(bus_req_o), 64'd0);
        check("t1_hold_n", 64'(hold_flag_mem_o), 64'd1);
        step();
        check("t1_req_n1", 64'(bus_req_o), 64'd1);
        check("t1_addr_n1", bus_addr_o, 64'h80);
        check("t1_hold_n1", 64'(hold_flag_mem_o), 64'd1);
        step();
        check("t1_rvalid_n2", 64'(mem_rvalid_o), 64'd1);
        check("t1_hold_n2", 64'(hold_flag_mem_o), 64'd0);
        check("t1_req_n2", 64'(bus_req_o), 64'd0);
        s_mem_req = 1'b0;

        // Starvation: four MEM grants, then IF forced through
        s_if_addr = 64'h1000; s_if_req = 1'b1;
        if_q.push_back(mem_data(64'h1000));
        for (int k = 0; k < 4; k++) begin
            s_mem_addr = 64'h2000 + 64'(8 * k); s_mem_req = 1'b1;
            mem_push(1'b0, 8'h00, mem_data(s_mem_addr));
            step(); step();
            check("t2_mem_grant", bus_addr_o, s_mem_addr);
            check("t2_if_hold", 64'(hold_flag_if_o), 64'd1);
            step();
            check("t2_mem_done", 64'(mem_rvalid_o), 64'd1);
        end
        s_mem_addr = 64'h2020;
        mem_push(1'b0, 8'h00, mem_data(64'h2020));
        step(); step();
        check("t2_if_forced", bus_addr_o, 64'h1000);
        check("t2_mem_hold", 64'(hold_flag_mem_o), 64'd1);
        step();
        check("t2_if_done", 64'(if_rvalid_o), 64'd1);
        s_if_addr = 64'h1100;
        if_q.push_back(mem_data(64'h1100));
        step(); step();
        check("t2_cnt_cleared", bus_addr_o, 64'h2020);
        step();
        check("t2_mem5_done", 64'(mem_rvalid_o), 64'd1);
        s_mem_req = 1'b0;
        step(); step();
        check("t2_if2_grant", bus_addr_o, 64'h1100);
        step();
        check("t2_if2_done", 64'(if_rvalid_o), 64'd1);
        s_if_req = 1'b0;

        // Flush while an IF request waits for grant
        gnt_hold = 1'b1; s_if_addr = 64'h3000; s_if_req = 1'b1;
        step(); step();
        check("t3_if_addr", bus_addr_o, 64'h3000);
        check("t3_if_req", 64'(bus_req_o), 64'd1);
        s_mem_addr = 64'h4000; s_mem_req = 1'b1; s_flush = 1'b1;
        mem_push(1'b0, 8'h00, mem_data(64'h4000));
        step();
        check("t3_hold_if_flush", 64'(hold_flag_if_o), 64'd0);
        check("t3_no_if_rvalid", 64'(if_rvalid_o), 64'd0);
        s_flush = 1'b0; s_if_req = 1'b0; gnt_hold = 1'b0;
        step();
        check("t3_req_dropped", 64'(bus_req_o), 64'd0);
        step();
        check("t3_mem_next", bus_addr_o, 64'h4000);
        check("t3_mem_req", 64'(bus_req_o), 64'd1);
        step();
        check("t3_mem_done", 64'(mem_rvalid_o), 64'd1);
        s_mem_req = 1'b0;

        // Flush during DATA; the late response must be swallowed
        rsp_delay = 4; s_if_addr = 64'h5000; s_if_req = 1'b1;
        step(); step();
        check("t4_if_grant", bus_addr_o, 64'h5000);
        s_flush = 1'b1;
        step();
        check("t4_flush_hold", 64'(hold_flag_if_o), 64'd0);
        s_flush = 1'b0; s_if_addr = 64'h6000;
        if_q.push_back(mem_data(64'h6000));
        step(); step(); step();
        check("t4_discarded", 64'(if_rvalid_o), 64'd0);
        check("t4_discard_hold", 64'(hold_flag_if_o), 64'd1);
        rsp_delay = 1;
        step(); step();
        check("t4_new_addr", bus_addr_o, 64'h6000);
        step();
        check("t4_new_done", 64'(if_rvalid_o), 64'd1);
        s_if_req = 1'b0;

        // Store with grant held for one cycle
        gnt_hold = 1'b1; s_mem_addr = 64'h7000; s_mem_we = 1'b1;
        s_mem_wdata = 64'hDEAD_BEEF; s_mem_wmask = 8'h0F; s_mem_req = 1'b1;
        mem_push(1'b1, 8'h0F, 64'hDEAD_BEEF);
        step(); step();
        check("t5_we", 64'(bus_we_o), 64'd1);
        check("t5_wmask", 64'(bus_wmask_o), 64'h0F);
        check("t5_wdata", bus_wdata_o, 64'hDEAD_BEEF);
        gnt_hold = 1'b0;
        step();
        check("t5_we_gnt", 64'(bus_we_o), 64'd1);
        check("t5_wmask_gnt", 64'(bus_wmask_o), 64'h0F);
        step();
        check("t5_ack", 64'(mem_rvalid_o), 64'd1);
        s_mem_req = 1'b0; s_mem_we = 1'b0; s_mem_wmask = 8'h00;

        // Reset mid-transaction, then a clean fetch
        rsp_delay = 3; s_mem_addr = 64'h8000; s_mem_req = 1'b1;
        step(); step(); step();
        s_rst_n = 1'b0; s_mem_req = 1'b0;
        step();
        s_rst_n = 1'b1;
        step();
        check("t6_rst_req", 64'(bus_req_o), 64'd0);
        check("t6_rst_we", 64'(bus_we_o), 64'd0);
        check("t6_rst_addr", bus_addr_o, 64'd0);
        check("t6_rst_wdata", bus_wdata_o, 64'd0);
        check("t6_rst_wmask", 64'(bus_wmask_o), 64'd0);
        check("t6_rst_if_rvalid", 64'(if_rvalid_o), 64'd0);
        check("t6_rst_mem_rvalid", 64'(mem_rvalid_o), 64'd0);
        rsp_delay = 1; s_if_addr = 64'h9000; s_if_req = 1'b1;
        if_q.push_back(mem_data(64'h9000));
        step();
        check("t6_if_hold", 64'(hold_flag_if_o), 64'd1);
        step();
        check("t6_if_addr", bus_addr_o, 64'h9000);
        step();
        check("t6_if_done", 64'(if_rvalid_o), 64'd1);
        s_if_req = 1'b0;
        step(); step();

        check("if_q_drained", 64'(if_q.size()), 64'd0);
        check("mem_q_drained", 64'(mem_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
